imem_boot_ctrl: RTL

//  Boot/load sequencer for the byte-organised instruction memory (8-bit cells, big-endian 32-bit words).

---
 rtl/imem_boot_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/imem_boot_ctrl.sv
// Boot/load sequencer: streams 32-bit words into byte-wide instruction memory (big-endian), then releases the CPU.
// Optional build macro IMEM_CHECKSUM_EN adds a trailing checksum-word verification state and a live csum port.
module imem_boot_ctrl #(
    parameter int WORD_LEN       = 32,
    parameter int MEM_CELL_SIZE  = 8,
    parameter int INSTR_MEM_SIZE = 1024,
    parameter int ADDR_W         = $clog2(INSTR_MEM_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     run_skip,
    input  logic                     ld_valid,
    input  logic [WORD_LEN-1:0]      ld_data,
    input  logic                     ld_last,
    output logic                     ld_ready,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [MEM_CELL_SIZE-1:0] mem_wdata,
    output logic                     cpu_stall,
    output logic                     boot_done,
    output logic                     boot_err,
    output logic [ADDR_W-1:0]        word_count,
    output logic [WORD_LEN-1:0]      csum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
`ifdef IMEM_CHECKSUM_EN
        S_CHK,
`endif
        S_RUN,
        S_ERR
    } state_t;

    // base is one bit wider than the address so a completely full memory is distinguishable from 0
    localparam logic [ADDR_W:0] BASE_FULL = (ADDR_W+1)'(INSTR_MEM_SIZE);
    localparam logic [ADDR_W:0] BASE_STEP = (ADDR_W+1)'(4);

    state_t                state, state_n;
    logic [ADDR_W:0]       base;
    logic [1:0]            idx;
    logic [WORD_LEN-1:0]   word_buf;
    logic                  last_f;
    logic [ADDR_W-1:0]     word_cnt_q;
    logic                  clr, accept, word_end;

`ifdef IMEM_CHECKSUM_EN
    logic [WORD_LEN-1:0]   csum_q;
    assign csum = csum_q;
`else
    assign csum = '0;
`endif

    assign word_count = word_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_stall = 1'b1;
        boot_done = 1'b0;
        boot_err  = 1'b0;
        clr       = 1'b0;
        accept    = 1'b0;
        word_end  = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_n = S_LOAD;
                    clr     = 1'b1;
                end else if (run_skip) begin
                    state_n = S_RUN;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    if (base == BASE_FULL) begin
                        state_n = S_ERR;
                    end else begin
                        state_n = S_WRITE;
                        accept  = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = base[ADDR_W-1:0] + ADDR_W'(idx);
                mem_wdata = word_buf[(WORD_LEN-1) - MEM_CELL_SIZE*idx -: MEM_CELL_SIZE];
                if (idx == 2'd3) begin
                    word_end = 1'b1;
`ifdef IMEM_CHECKSUM_EN
                    state_n  = last_f ? S_CHK : S_LOAD;
`else
                    state_n  = last_f ? S_RUN : S_LOAD;
`endif
                end
            end
`ifdef IMEM_CHECKSUM_EN
            S_CHK: begin
                ld_ready = 1'b1;
                if (ld_valid) state_n = (ld_data == csum_q) ? S_RUN : S_ERR;
            end
`endif
            S_RUN: begin
                cpu_stall = 1'b0;
                boot_done = 1'b1;
                mem_addr  = fetch_addr;
                if (load_start) begin
                    state_n = S_LOAD;
                    clr     = 1'b1;
                end
            end
            S_ERR: begin
                boot_err = 1'b1;
                if (load_start) begin
                    state_n = S_LOAD;
                    clr     = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base       <= '0;
            idx        <= '0;
            word_buf   <= '0;
            last_f     <= 1'b0;
            word_cnt_q <= '0;
`ifdef IMEM_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            if (clr) begin
                base       <= '0;
                word_cnt_q <= '0;
`ifdef IMEM_CHECKSUM_EN
                csum_q     <= '0;
`endif
            end
            if (accept) begin
                word_buf <= ld_data;
                last_f   <= ld_last;
                idx      <= '0;
            end
            if (state == S_WRITE) idx <= idx + 2'd1;
            if (word_end) begin
                base       <= base + BASE_STEP;
                word_cnt_q <= word_cnt_q + ADDR_W'(1);
`ifdef IMEM_CHECKSUM_EN
                csum_q     <= csum_q + word_buf;
`endif
            end
        end
    end

endmodule
